// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the device-side PS/2 transmitter:
//   - ps2_state_e : transmitter FSM states (IDLE, HIGH, LOW, GAP)
//   - FRAME_BITS, START_BIT, STOP_BIT, LAST_BIT : frame layout constants
//   - odd_parity() : parity bit sent after the eight data bits
//   - ps2_cnt_width() : width of the shared half-period / gap down-counter
// ---------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        GAP  = 2'd3
    } ps2_state_e;

    localparam int         FRAME_BITS = 11;
    localparam logic       START_BIT  = 1'b0;
    localparam logic       STOP_BIT   = 1'b1;
    localparam logic [3:0] LAST_BIT   = 4'd10;

    // PS/2 parity makes the total count of ones in data + parity odd.
    function automatic logic odd_parity(input logic [7:0] data_byte);
        return ~(^data_byte);
    endfunction

    // One counter serves both phase lengths, so it is sized for the larger
    // reload value; it never needs fewer than one bit.
    function automatic int ps2_cnt_width(input int half_period, input int gap_cycles);
        int w_hp;
        int w_gap;
        int w_max;
        w_hp  = $clog2(half_period);
        w_gap = $clog2(gap_cycles);
        w_max = (w_hp > w_gap) ? w_hp : w_gap;
        return (w_max < 1) ? 1 : w_max;
    endfunction

endpackage

// File: rtl/ps2_device_tx_half_timer.sv
// ---------------------------------------------------------------------------
// ps2_half_timer
// Down-counter timing one PS/2 clock half-period or the inter-byte gap.
// Loading N-1 makes o_tick rise on the N-th cycle of the phase, so the FSM
// moves on at the edge that ends that cycle. The counter parks at zero and
// never wraps.
// Ports:
//   clk        in   system clock
//   n_reset    in   asynchronous active-low reset
//   i_load     in   load i_load_val this cycle (wins over counting)
//   i_load_val in   reload value (phase length - 1)
//   o_tick     out  count has reached zero
// ---------------------------------------------------------------------------
module ps2_half_timer #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_tick
);

    logic [CNT_W-1:0] r_cnt;

    // Phase counter: reload on request, otherwise count down and hold at zero.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != {CNT_W{1'b0}}) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_tick = (r_cnt == {CNT_W{1'b0}});

endmodule

// File: rtl/ps2_device_tx.sv
// ---------------------------------------------------------------------------
// ps2_device_tx
// Device-side PS/2 keyboard transmitter. Accepts scancode bytes with a
// valid/ready handshake and serialises each as an 11-bit frame (start 0,
// data LSB first, odd parity, stop 1). Every bit is a HIGH half-period
// followed by a LOW half-period of ps2_clk; ps2_data only changes on the
// first cycle of HIGH so the host sees it stable at the falling edge.
// After the stop bit the clock is released for one more half-period, then
// both lines stay high for GAP_CYCLES before the next byte is taken.
//
// Optional build macro: PS2_INHIBIT_EN
//   Synchronises ps2_clk_in; a low host clock defers new bytes in IDLE and
//   aborts a frame during the HIGH phase of bits 0..9, after which the
//   retained byte is resent automatically once the line is released.
//   Without the macro ps2_clk_in is ignored.
//
// Ports:
//   clk         in   system clock (25 MHz pixel clock)
//   n_reset     in   asynchronous active-low reset
//   tx_data     in   byte to send, held stable while tx_valid is high
//   tx_valid    in   tx_data is valid
//   tx_ready    out  byte accepted on this edge if tx_valid is high
//   ps2_clk_in  in   sensed PS/2 clock line (inhibit build only)
//   ps2_clk     out  driven PS/2 clock, idle high
//   ps2_data    out  driven PS/2 data, idle high
//   busy        out  frame or gap in progress
// ---------------------------------------------------------------------------
module ps2_device_tx
    import ps2_pkg::*;
#(
    parameter int HALF_PERIOD = 1000,
    parameter int GAP_CYCLES  = 2500
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy
);

    localparam int               CNT_W    = ps2_cnt_width(HALF_PERIOD, GAP_CYCLES);
    localparam logic [CNT_W-1:0] HP_LOAD  = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

    ps2_state_e       r_state;
    logic [3:0]       r_bit;
    logic [9:0]       r_shift;      // {stop, parity, data[7:0]} still to send
    logic [7:0]       r_byte;       // kept for retransmission after an abort
    logic             r_release;    // HIGH phase is the post-stop clock release
    logic             r_retx;       // resend r_byte when the gap ends
    logic             r_ps2_clk;
    logic             r_ps2_data;
    logic             r_tx_ready;
    logic             r_busy;

    ps2_state_e       w_state_nxt;
    logic [3:0]       w_bit_nxt;
    logic [9:0]       w_shift_nxt;
    logic [7:0]       w_byte_nxt;
    logic             w_release_nxt;
    logic             w_retx_nxt;
    logic             w_clk_nxt;
    logic             w_data_nxt;
    logic             w_ready_nxt;
    logic             w_busy_nxt;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_tick;
    logic             w_line_ok;    // host is not holding the clock low

`ifdef PS2_INHIBIT_EN
    logic [1:0] r_sync;

    // Two-flop synchroniser for the host-driven clock line; idles released.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], ps2_clk_in};
        end
    end

    assign w_line_ok = r_sync[1];
`else
    logic w_unused_clk_in;
    assign w_unused_clk_in = ps2_clk_in;
    assign w_line_ok       = 1'b1;
`endif

    ps2_half_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .n_reset    (n_reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_tick     (w_tick)
    );

    // Next-state, next-output and datapath update for the frame FSM.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_nxt     = r_bit;
        w_shift_nxt   = r_shift;
        w_byte_nxt    = r_byte;
        w_release_nxt = r_release;
        w_retx_nxt    = r_retx;
        w_clk_nxt     = r_ps2_clk;
        w_data_nxt    = r_ps2_data;
        w_load        = 1'b0;
        w_load_val    = HP_LOAD;

        case (r_state)
            IDLE: begin
                w_clk_nxt  = 1'b1;
                if (tx_valid && r_tx_ready) begin
                    w_state_nxt   = HIGH;
                    w_bit_nxt     = 4'd0;
                    w_byte_nxt    = tx_data;
                    w_shift_nxt   = {STOP_BIT, odd_parity(tx_data), tx_data};
                    w_release_nxt = 1'b0;
                    w_data_nxt    = START_BIT;
                    w_load        = 1'b1;
                    w_load_val    = HP_LOAD;
                end else begin
                    w_data_nxt    = 1'b1;
                end
            end

            HIGH: begin
                // Host inhibit before the stop bit: drop the frame, keep the byte.
                if (!w_line_ok && !r_release && (r_bit != LAST_BIT)) begin
                    w_state_nxt = GAP;
                    w_clk_nxt   = 1'b1;
                    w_data_nxt  = 1'b1;
                    w_retx_nxt  = 1'b1;
                    w_load      = 1'b1;
                    w_load_val  = GAP_LOAD;
                end else if (w_tick) begin
                    if (r_release) begin
                        w_state_nxt   = GAP;
                        w_release_nxt = 1'b0;
                        w_load        = 1'b1;
                        w_load_val    = GAP_LOAD;
                    end else begin
                        w_state_nxt   = LOW;
                        w_clk_nxt     = 1'b0;
                        w_load        = 1'b1;
                        w_load_val    = HP_LOAD;
                    end
                end else begin
                    w_state_nxt = HIGH;
                end
            end

            LOW: begin
                if (w_tick) begin
                    w_state_nxt = HIGH;
                    w_clk_nxt   = 1'b1;
                    w_load      = 1'b1;
                    w_load_val  = HP_LOAD;
                    if (r_bit == LAST_BIT) begin
                        w_release_nxt = 1'b1;
                        w_data_nxt    = 1'b1;
                    end else begin
                        w_bit_nxt     = r_bit + 4'd1;
                        w_data_nxt    = r_shift[0];
                        w_shift_nxt   = {1'b1, r_shift[9:1]};
                    end
                end else begin
                    w_state_nxt = LOW;
                end
            end

            GAP: begin
                // The gap only starts counting once the host lets go of the clock.
                if (!w_line_ok) begin
                    w_load     = 1'b1;
                    w_load_val = GAP_LOAD;
                end else if (w_tick) begin
                    if (r_retx) begin
                        w_state_nxt   = HIGH;
                        w_retx_nxt    = 1'b0;
                        w_bit_nxt     = 4'd0;
                        w_shift_nxt   = {STOP_BIT, odd_parity(r_byte), r_byte};
                        w_release_nxt = 1'b0;
                        w_clk_nxt     = 1'b1;
                        w_data_nxt    = START_BIT;
                        w_load        = 1'b1;
                        w_load_val    = HP_LOAD;
                    end else begin
                        w_state_nxt   = IDLE;
                    end
                end else begin
                    w_state_nxt = GAP;
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_clk_nxt   = 1'b1;
                w_data_nxt  = 1'b1;
            end
        endcase

        // Ready/busy follow from staying in IDLE, so ready drops on the accept
        // edge and rises one cycle after the FSM returns to IDLE.
        w_ready_nxt = (r_state == IDLE) && (w_state_nxt == IDLE) && w_line_ok;
        w_busy_nxt  = !((r_state == IDLE) && (w_state_nxt == IDLE));
    end

    // FSM state, frame datapath and registered line/handshake outputs.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state    <= IDLE;
            r_bit      <= 4'd0;
            r_shift    <= 10'd0;
            r_byte     <= 8'd0;
            r_release  <= 1'b0;
            r_retx     <= 1'b0;
            r_ps2_clk  <= 1'b1;
            r_ps2_data <= 1'b1;
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit      <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_byte     <= w_byte_nxt;
            r_release  <= w_release_nxt;
            r_retx     <= w_retx_nxt;
            r_ps2_clk  <= w_clk_nxt;
            r_ps2_data <= w_data_nxt;
            r_tx_ready <= w_ready_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign tx_ready = r_tx_ready;
    assign ps2_clk  = r_ps2_clk;
    assign ps2_data = r_ps2_data;
    assign busy     = r_busy;

endmodule

// File: tb/tb_ps2_device_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_device_tx
// Directed bench for ps2_device_tx with HALF_PERIOD=4, GAP_CYCLES=6.
// Frames are captured by sampling ps2_data whenever ps2_clk falls; expected
// frames are written out by hand as {stop, parity, data, start}.
// ---------------------------------------------------------------------------
module tb_ps2_device_tx;

    localparam int HP  = 4;
    localparam int GAP = 6;
    localparam int FRAME_LAT = 1 + 22*HP + HP + GAP;   // 99

    logic       clk;
    logic       n_reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_clk;
    logic       ps2_data;
    logic       busy;

    int tests;
    int fails;

    logic [10:0] bits;
    logic [10:0] bits1;
    logic [10:0] bits2;
    int          nfall;
    int          falls1;
    int          falls2;
    int          lat;
    int          accepts;
    int          gap_cnt;
    int          overlap;
    logic        in_gap;
    logic        prev_clk;
    logic        will;
    logic        done;

    ps2_device_tx #(
        .HALF_PERIOD (HP),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until tx_ready is seen high.
    task automatic wait_ready(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (tx_ready) break;
            step();
        end
        check(tag, {31'd0, tx_ready}, 32'd1);
    endtask

    // From the cycle after accept: collect bits on falling ps2_clk until
    // tx_ready returns; lat counts edges from accept to tx_ready high.
    task automatic capture(output logic [10:0] fr, output int nf, output int lt);
        logic pc;
        fr = 11'd0;
        nf = 0;
        lt = 0;
        pc = ps2_clk;
        for (int i = 0; i < 400; i++) begin
            step();
            lt++;
            if (pc && !ps2_clk) begin
                if (nf < 11) fr[nf] = ps2_data;
                nf++;
            end
            pc = ps2_clk;
            if (tx_ready) break;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, output logic [10:0] fr, output int nf, output int lt);
        wait_ready("wait_ready");
        tx_data  = d;
        tx_valid = 1'b1;
        step();                 // accept edge
        tx_valid = 1'b0;
        capture(fr, nf, lt);
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        n_reset    = 1'b0;
        tx_data    = 8'h00;
        tx_valid   = 1'b1;
        ps2_clk_in = 1'b1;

        // ---- reset: valid pulsed while held in reset ----
        repeat (3) step();
        check("rst_clk",   {31'd0, ps2_clk},  32'd1);
        check("rst_data",  {31'd0, ps2_data}, 32'd1);
        check("rst_ready", {31'd0, tx_ready}, 32'd0);
        check("rst_busy",  {31'd0, busy},     32'd0);
        tx_valid = 1'b0;
        n_reset  = 1'b1;
        #1;
        check("rel_ready_before_edge", {31'd0, tx_ready}, 32'd0);
        step();
        check("rel_ready_first_edge", {31'd0, tx_ready}, 32'd1);

        // ---- 8'h1C: 0001_1100, three ones -> parity 0 ----
        send_frame(8'h1C, bits, nfall, lat);
        check("1C_bits",  {21'd0, bits}, {21'd0, 11'b1_0_00011100_0});
        check("1C_falls", nfall, 11);
        check("1C_lat",   lat, FRAME_LAT);

        // ---- parity corner bytes ----
        send_frame(8'h00, bits, nfall, lat);
        check("00_bits", {21'd0, bits}, {21'd0, 11'b1_1_00000000_0});
        send_frame(8'hFF, bits, nfall, lat);
        check("FF_bits", {21'd0, bits}, {21'd0, 11'b1_1_11111111_0});
        send_frame(8'h01, bits, nfall, lat);
        check("01_bits", {21'd0, bits}, {21'd0, 11'b1_0_00000001_0});
        check("01_lat",  lat, FRAME_LAT);

        // ---- back-to-back F0 then 1C with tx_valid held high ----
        wait_ready("b2b_wait");
        tx_data  = 8'hF0;
        tx_valid = 1'b1;
        step();                 // accept F0
        tx_data  = 8'h1C;
        accepts  = 1;
        falls1   = 0;
        falls2   = 0;
        bits1    = 11'd0;
        bits2    = 11'd0;
        gap_cnt  = 0;
        overlap  = 0;
        in_gap   = 1'b0;
        done     = 1'b0;
        prev_clk = ps2_clk;
        for (int c = 0; c < 400; c++) begin
            if (done) break;
            if (tx_ready && tx_valid && accepts == 2) begin
                tx_valid = 1'b0;
                done     = 1'b1;
            end else begin
                will = tx_ready && tx_valid;
                step();
                if (will) accepts++;
                if (tx_ready && busy) overlap++;
                if (prev_clk && !ps2_clk) begin
                    if (accepts == 1) begin
                        if (falls1 < 11) bits1[falls1] = ps2_data;
                        falls1++;
                        if (falls1 == 11) in_gap = 1'b1;
                    end else begin
                        if (falls2 < 11) bits2[falls2] = ps2_data;
                        falls2++;
                    end
                end
                if (in_gap && !ps2_data) in_gap = 1'b0;
                if (in_gap && ps2_clk && ps2_data) gap_cnt++;
                prev_clk = ps2_clk;
            end
        end
        check("b2b_done",     {31'd0, done}, 32'd1);
        check("b2b_accepts",  accepts, 2);
        check("b2b_falls1",   falls1, 11);
        check("b2b_falls2",   falls2, 11);
        check("b2b_bits_F0",  {21'd0, bits1}, {21'd0, 11'b1_1_11110000_0});
        check("b2b_bits_1C",  {21'd0, bits2}, {21'd0, 11'b1_0_00011100_0});
        check("b2b_ready_busy_overlap", overlap, 0);
        // 4 release + 6 gap + ready registration cycle + accept cycle
        check("b2b_lines_high", gap_cnt, HP + GAP + 2);

        // ---- reset in bit 5 (LOW phase, data = d4 of E0 = 0) ----
        wait_ready("mid_wait");
        tx_data  = 8'hE0;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        repeat (46) step();     // bit 5 LOW spans cycles 44..47
        check("mid_pre_clk",  {31'd0, ps2_clk},  32'd0);
        check("mid_pre_data", {31'd0, ps2_data}, 32'd0);
        #2;
        n_reset = 1'b0;
        #1;
        check("mid_rst_clk",   {31'd0, ps2_clk},  32'd1);
        check("mid_rst_data",  {31'd0, ps2_data}, 32'd1);
        check("mid_rst_ready", {31'd0, tx_ready}, 32'd0);
        check("mid_rst_busy",  {31'd0, busy},     32'd0);
        step();
        n_reset = 1'b1;
        step();
        check("mid_rel_ready", {31'd0, tx_ready}, 32'd1);
        send_frame(8'h32, bits, nfall, lat);
        check("32_bits",  {21'd0, bits}, {21'd0, 11'b1_0_00110010_0});
        check("32_falls", nfall, 11);
        check("32_lat",   lat, FRAME_LAT);

`ifdef PS2_INHIBIT_EN
        // ---- host inhibit during bit 3, then automatic resend ----
        wait_ready("inh_wait");
        tx_data  = 8'h1C;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        repeat (24) step();     // bit 3 HIGH starts at cycle 24
        ps2_clk_in = 1'b0;
        repeat (4) step();      // would be bit 3 LOW without the abort
        check("inh_abort_clk",  {31'd0, ps2_clk},  32'd1);
        check("inh_abort_data", {31'd0, ps2_data}, 32'd1);
        check("inh_abort_busy", {31'd0, busy},     32'd1);
        repeat (10) step();
        check("inh_hold_clk", {31'd0, ps2_clk}, 32'd1);
        ps2_clk_in = 1'b1;
        capture(bits, nfall, lat);
        check("inh_resend_bits",  {21'd0, bits}, {21'd0, 11'b1_0_00011100_0});
        check("inh_resend_falls", nfall, 11);
        // ---- inhibit while idle keeps tx_ready low ----
        ps2_clk_in = 1'b0;
        tx_data    = 8'h55;
        tx_valid   = 1'b1;
        repeat (4) step();
        check("inh_idle_ready", {31'd0, tx_ready}, 32'd0);
        check("inh_idle_busy",  {31'd0, busy},     32'd0);
        tx_valid   = 1'b0;
        ps2_clk_in = 1'b1;
        repeat (4) step();
        check("inh_idle_release_ready", {31'd0, tx_ready}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
